// File: rtl/extend.sv
// extend: immediate generator for the LumosRV RV32I datapath.
// Sign-extends the immediate field of an instruction word in the format
// chosen by the control unit, and also provides a registered copy for
// pipelined datapaths.
//
// Ports:
//   ImmExt  (out, 32) combinational sign-extended immediate
//   ImmSrc  (in,   2) format select: 00 = I, 01 = S, 10 = B, 11 = J
//   Instr   (in,  32) current instruction word
//   clk     (in,   1) rising-edge clock, used only by ImmExtQ
//   reset   (in,   1) asynchronous active-high reset, clears ImmExtQ
//   ImmExtQ (out, 32) ImmExt registered on clk
module extend (
  output logic [31:0] ImmExt,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Instr,
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ImmExtQ
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immFmt_t;

  immFmt_t fmt;
  assign fmt = immFmt_t'(ImmSrc);

  // The opcode field never carries immediate bits; only the select decides
  // the format, so these bits are deliberately ignored.
  logic unusedOpcode;
  assign unusedOpcode = ^Instr[6:0];

  // Format mux; J is the default arm so an unknown select cannot yield X.
  always_comb begin
    ImmExt = '0;
    case (fmt)
      IMM_I:   ImmExt = {{20{Instr[31]}}, Instr[31:20]};
      IMM_S:   ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B:   ImmExt = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      default: ImmExt = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
    endcase
  end

  // Pipeline copy of the immediate; clears as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ImmExtQ <= XLEN'(0);
    else       ImmExtQ <= ImmExt;
  end

endmodule

// File: tb/tb_extend.sv
// tb_extend: directed self-checking bench for the immediate generator.
// Drives instruction/select pairs with hand-computed immediates, then
// exercises the registered copy through clocking and asynchronous reset.
module tb_extend;

  logic [31:0] ImmExt;
  logic [1:0]  ImmSrc;
  logic [31:0] Instr;
  logic        clk;
  logic        reset;
  logic [31:0] ImmExtQ;

  int errors = 0;
  int checks = 0;

  extend dut (
    .ImmExt (ImmExt),
    .ImmSrc (ImmSrc),
    .Instr  (Instr),
    .clk    (clk),
    .reset  (reset),
    .ImmExtQ(ImmExtQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Apply a combinational vector and check ImmExt after a settle delay.
  task automatic combVec(input string tag, input logic [31:0] ins,
                         input logic [1:0] src, input logic [31:0] expected);
    Instr  = ins;
    ImmSrc = src;
    #1;
    check(tag, ImmExt, expected);
  endtask

  initial begin
    Instr  = 32'h0000_0000;
    ImmSrc = 2'b00;
    reset  = 1'b0;

    // Reset pulse between edges: register clears without a clock.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_async_q", ImmExtQ, 32'h0000_0000);
    check("zero_i", ImmExt, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;

    // Combinational formats, both signs.
    @(negedge clk);
    combVec("s_sw",       32'h0020_2223, 2'b01, 32'h0000_0004);
    combVec("i_addi",     32'h01C0_0113, 2'b00, 32'h0000_001C);
    combVec("i_lw",       32'h0040_2103, 2'b00, 32'h0000_0004);
    combVec("i_addi_m1",  32'hFFF0_0093, 2'b00, 32'hFFFF_FFFF);
    combVec("b_beq",      32'h0220_8263, 2'b10, 32'h0000_0024);
    combVec("b_neg",      32'hFE00_0EE3, 2'b10, 32'hFFFF_FFFC);
    combVec("j_jal",      32'h0080_006F, 2'b11, 32'h0000_0008);
    combVec("j_neg",      32'hFFDF_F06F, 2'b11, 32'hFFFF_FFFC);
    // Mismatched select still gives a defined value (I field of a jal).
    combVec("i_of_jal",   32'hFFDF_F06F, 2'b00, 32'hFFFF_FFFD);
    // Simultaneous change of word and select: S of addi -1 -> sign ext of {7F,01}.
    combVec("s_simul",    32'hFFF0_0093, 2'b01, 32'hFFFF_FFE1);

    // Registered path.
    @(negedge clk);
    Instr  = 32'h01C0_0113;
    ImmSrc = 2'b00;
    #1;
    check("q_pre_edge", ImmExtQ, 32'hFFFF_FFE1);
    @(posedge clk);
    #1;
    check("q_load", ImmExtQ, 32'h0000_001C);

    // Changing inputs without a clock must not move the register.
    @(negedge clk);
    combVec("j_between", 32'h0080_006F, 2'b11, 32'h0000_0008);
    check("q_hold", ImmExtQ, 32'h0000_001C);
    @(posedge clk);
    #1;
    check("q_load_j", ImmExtQ, 32'h0000_0008);

    // Mid-stream reset: immediate clear, held through an edge, ImmExt unaffected.
    @(negedge clk);
    Instr  = 32'h01C0_0113;
    ImmSrc = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check("q_reset_mid", ImmExtQ, 32'h0000_0000);
    check("ext_in_reset", ImmExt, 32'h0000_001C);
    @(posedge clk);
    #1;
    check("q_reset_hold", ImmExtQ, 32'h0000_0000);

    // Release and clock once: current immediate reloads.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("q_after_release", ImmExtQ, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("q_reload", ImmExtQ, 32'h0000_001C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
